// File: rtl/ysyx_23060124_pipe_skid_reg_if.sv
// Valid/ready handshake bundle for the pipeline skid register.
// The slave side is the register stage; the master side drives its upstream and downstream inputs.
interface ysyx_23060124_pipe_skid_reg_if #(
    parameter int DATA_W = 128
);
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_data;
    logic [1:0]        o_level;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_level
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_level
    );
endinterface

// File: rtl/ysyx_23060124_pipe_skid_reg.sv
// Pipeline register stage: a single-entry register with combinational ready (MODE=0)
// or a two-entry skid buffer with registered ready (MODE=1). Flush empties the stage.
module ysyx_23060124_pipe_skid_reg #(
    parameter int DATA_W       = 128,
    parameter int MODE         = 1,
    parameter int CLR_ON_FLUSH = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               i_flush,
    ysyx_23060124_pipe_skid_reg_if.slave       bus
);

    // State encoding doubles as the held-entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              ready;
    logic              in_xfer;
    logic              out_xfer;

    if (MODE == 1) begin : g_skid
        assign ready = !reset && !i_flush && (state_q != FULL);
    end else begin : g_single
        assign ready = !reset && !i_flush && ((state_q == EMPTY) || bus.i_ready);
    end

    assign in_xfer  = bus.i_valid && ready;
    assign out_xfer = (state_q != EMPTY) && bus.i_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (i_flush) begin
            state_d = EMPTY;
            if (CLR_ON_FLUSH != 0) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = BUSY;
                        main_d  = bus.i_data;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_d = bus.i_data;
                    end else if (in_xfer) begin
                        state_d = FULL;
                        skid_d  = bus.i_data;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = (state_q != EMPTY);
    assign bus.o_data  = main_q;
    assign bus.o_level = state_q;

endmodule

// File: tb/tb_ysyx_23060124_pipe_skid_reg.sv
// Bench for the pipeline skid register: directed scenarios on 32-bit instances plus
// randomized traffic on DATA_W 1/64 and MODE 0/1 instances against a queue model.
module tb_ysyx_23060124_pipe_skid_reg;

    logic clock = 1'b0;
    logic drst;
    logic rrst;
    logic dflush;
    bit   start_rnd;
    int   rnd_done;
    int   checks;
    int   failures;

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Directed instances
    ysyx_23060124_pipe_skid_reg_if #(.DATA_W(32)) di1 ();
    ysyx_23060124_pipe_skid_reg_if #(.DATA_W(32)) di0 ();

    ysyx_23060124_pipe_skid_reg #(.DATA_W(32), .MODE(1), .CLR_ON_FLUSH(1)) u_d1 (
        .clock   (clock),
        .reset   (drst),
        .i_flush (dflush),
        .bus     (di1)
    );

    ysyx_23060124_pipe_skid_reg #(.DATA_W(32), .MODE(0), .CLR_ON_FLUSH(1)) u_d0 (
        .clock   (clock),
        .reset   (drst),
        .i_flush (dflush),
        .bus     (di0)
    );

    // Randomized instances: g=0 (1,MODE0) g=1 (1,MODE1) g=2 (64,MODE0,no clear) g=3 (64,MODE1)
    for (genvar g = 0; g < 4; g++) begin : g_rnd
        localparam int RW = (g < 2) ? 1 : 64;
        localparam int RM = g % 2;
        localparam int RC = (g == 2) ? 0 : 1;

        ysyx_23060124_pipe_skid_reg_if #(.DATA_W(RW)) rif ();
        logic rflush;
        logic [RW-1:0] q[$];

        ysyx_23060124_pipe_skid_reg #(.DATA_W(RW), .MODE(RM), .CLR_ON_FLUSH(RC)) u_dut (
            .clock   (clock),
            .reset   (rrst),
            .i_flush (rflush),
            .bus     (rif)
        );

        initial begin
            bit acc;
            rflush      = 1'b0;
            rif.i_valid = 1'b0;
            rif.i_ready = 1'b0;
            rif.i_data  = '0;
            wait (start_rnd);
            for (int n = 0; n < 3000; n++) begin
                step();
                rif.i_valid = ($urandom_range(0, 3) != 0);
                rif.i_ready = ($urandom_range(0, 2) != 0);
                rflush      = ($urandom_range(0, 31) == 0);
                rif.i_data  = RW'({$urandom(), $urandom()});
                if (RM == 1)
                    acc = rif.i_valid && !rflush && (q.size() < 2);
                else
                    acc = rif.i_valid && !rflush && ((q.size() == 0) || rif.i_ready);
                @(negedge clock);
                #2;
                if (acc) q.push_back(rif.i_data);
            end
            step();
            rif.i_valid = 1'b0;
            rflush      = 1'b0;
            rnd_done++;
        end

        initial begin
            logic [RW-1:0] prev_d;
            bit            prev_stall;
            bit            exp_rdy;
            prev_stall = 1'b0;
            prev_d     = '0;
            wait (start_rnd);
            forever begin
                @(negedge clock);
                if (RM == 1)
                    exp_rdy = !rflush && (q.size() < 2);
                else
                    exp_rdy = !rflush && ((q.size() == 0) || rif.i_ready);
                chk("rnd_ready", 64'(rif.o_ready), 64'(exp_rdy));
                chk("rnd_level", 64'(rif.o_level), 64'(q.size()));
                chk("rnd_valid", 64'(rif.o_valid), 64'(q.size() != 0));
                if (q.size() != 0) chk("rnd_data", 64'(rif.o_data), 64'(q[0]));
                if (prev_stall) chk("rnd_stable", 64'(rif.o_data), 64'(prev_d));
                prev_stall = rif.o_valid && !rif.i_ready && !rflush;
                prev_d     = rif.o_data;
                if (rif.o_valid && rif.i_ready && (q.size() != 0)) void'(q.pop_front());
                if (rflush) q.delete();
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, failures=%0d", failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        drst = 1'b1; rrst = 1'b1; dflush = 1'b0; start_rnd = 1'b0;
        di1.i_valid = 1'b0; di1.i_ready = 1'b0; di1.i_data = '0;
        di0.i_valid = 1'b0; di0.i_ready = 1'b0; di0.i_data = '0;

        // Reset state
        step(); #3;
        chk("rst_ready_m1", 64'(di1.o_ready), 64'd0);
        chk("rst_ready_m0", 64'(di0.o_ready), 64'd0);
        chk("rst_valid", 64'(di1.o_valid), 64'd0);
        chk("rst_level", 64'(di1.o_level), 64'd0);
        chk("rst_data", 64'(di1.o_data), 64'd0);
        step(); drst = 1'b0; #3;
        chk("post_rst_ready_m1", 64'(di1.o_ready), 64'd1);
        chk("post_rst_ready_m0", 64'(di0.o_ready), 64'd1);

        // Streaming 1..8
        for (int k = 1; k <= 9; k++) begin
            step();
            di1.i_valid = (k <= 8);
            di1.i_data  = 32'(k);
            di1.i_ready = 1'b1;
            #3;
            if (k >= 2) begin
                chk("stream_data", 64'(di1.o_data), 64'(k - 1));
                chk("stream_level", 64'(di1.o_level), 64'd1);
            end
        end
        step(); di1.i_valid = 1'b0; di1.i_ready = 1'b0; #3;
        chk("stream_drain_level", 64'(di1.o_level), 64'd0);

        // Backpressure: A then B with downstream stalled
        step(); di1.i_valid = 1'b1; di1.i_data = 32'hA; di1.i_ready = 1'b0;
        step(); di1.i_data = 32'hB; #3;
        chk("bp_first_data", 64'(di1.o_data), 64'hA);
        step(); di1.i_valid = 1'b0; #3;
        chk("bp_level_full", 64'(di1.o_level), 64'd2);
        chk("bp_ready_full", 64'(di1.o_ready), 64'd0);
        chk("bp_hold_data", 64'(di1.o_data), 64'hA);
        step(); di1.i_ready = 1'b1; #3;
        chk("bp_out_a", 64'(di1.o_data), 64'hA);
        chk("bp_out_a_valid", 64'(di1.o_valid), 64'd1);
        step(); #3;
        chk("bp_out_b", 64'(di1.o_data), 64'hB);
        chk("bp_level_1", 64'(di1.o_level), 64'd1);
        chk("bp_ready_after", 64'(di1.o_ready), 64'd1);
        step(); di1.i_ready = 1'b0; #3;
        chk("bp_level_0", 64'(di1.o_level), 64'd0);
        chk("bp_valid_0", 64'(di1.o_valid), 64'd0);

        // Flush from FULL with a competing input
        step(); di1.i_valid = 1'b1; di1.i_data = 32'h11;
        step(); di1.i_data = 32'h22;
        step(); di1.i_data = 32'hC; dflush = 1'b1; #3;
        chk("fl_level_before", 64'(di1.o_level), 64'd2);
        chk("fl_ready", 64'(di1.o_ready), 64'd0);
        step(); dflush = 1'b0; di1.i_valid = 1'b0; di1.i_ready = 1'b1; #3;
        chk("fl_valid", 64'(di1.o_valid), 64'd0);
        chk("fl_level", 64'(di1.o_level), 64'd0);
        chk("fl_data", 64'(di1.o_data), 64'd0);
        step(); #3;
        chk("fl_no_c", 64'(di1.o_valid), 64'd0);

        // Combinational ready in MODE=0
        step(); di0.i_valid = 1'b1; di0.i_data = 32'h3; di0.i_ready = 1'b0; #3;
        chk("m0_ready_empty", 64'(di0.o_ready), 64'd1);
        step(); di0.i_data = 32'h5; #3;
        chk("m0_valid", 64'(di0.o_valid), 64'd1);
        chk("m0_ready_stall", 64'(di0.o_ready), 64'd0);
        chk("m0_data_3", 64'(di0.o_data), 64'h3);
        di0.i_ready = 1'b1; #1;
        chk("m0_ready_comb", 64'(di0.o_ready), 64'd1);
        step(); di0.i_valid = 1'b0; #3;
        chk("m0_data_5", 64'(di0.o_data), 64'h5);
        chk("m0_level_1", 64'(di0.o_level), 64'd1);
        step(); di0.i_ready = 1'b0; #3;
        chk("m0_level_0", 64'(di0.o_level), 64'd0);

        // Reset mid-stream while FULL
        step(); di1.i_valid = 1'b1; di1.i_data = 32'h33; di1.i_ready = 1'b0;
        step(); di1.i_data = 32'h44;
        step(); di1.i_data = 32'h77; di1.i_ready = 1'b1; drst = 1'b1; #3;
        chk("mr_level_before", 64'(di1.o_level), 64'd2);
        chk("mr_ready_in_rst", 64'(di1.o_ready), 64'd0);
        step(); drst = 1'b0; di1.i_valid = 1'b0; #3;
        chk("mr_valid", 64'(di1.o_valid), 64'd0);
        chk("mr_data", 64'(di1.o_data), 64'd0);
        chk("mr_level", 64'(di1.o_level), 64'd0);
        chk("mr_ready", 64'(di1.o_ready), 64'd1);
        di1.i_ready = 1'b0;

        // Randomized phase
        step(); rrst = 1'b0;
        step(); start_rnd = 1'b1;
        wait (rnd_done == 4);
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_23060124_pipe_skid_reg.md
YSYX_23060124_PIPE_SKID_REG -- requirements
Module: ysyx_23060124_pipe_skid_reg

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high. Ports are named clock and reset.
REQ-002 Parameter DATA_W, default 128: payload width in bits; legal for any value >= 1.
REQ-003 Parameter MODE, default 1: 0 = single-entry register (combinational ready); 1 = two-entry skid buffer (registered ready).
REQ-004 Parameter CLR_ON_FLUSH, default 1: 1 = zero data registers on flush; 0 = hold data registers on flush.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 i_flush  input  1  discard all held entries (branch/trap redirect).
REQ-008 i_valid  input  1  upstream payload valid.
REQ-009 o_ready  output  1  stage accepts payload this cycle.
REQ-010 i_data  input  DATA_W  upstream payload.
REQ-011 o_valid  output  1  downstream payload valid.
REQ-012 i_ready  input  1  downstream accepts payload.
REQ-013 o_data  output  DATA_W  downstream payload, driven from the main register.
REQ-014 o_level  output  2  held entries: 0, 1 or 2 (2 only when MODE=1).

Function
REQ-015 Input transfer SHALL occur when i_valid && o_ready. Output transfer SHALL occur when o_valid && i_ready.
REQ-016 Payload latency SHALL be 1 cycle: an input transfer at edge N is visible on o_data/o_valid after edge N.
REQ-017 MODE=0: o_ready = !reset && !i_flush && (!o_valid || i_ready).
- An input transfer SHALL load the main register.
- An output transfer with no input transfer SHALL clear o_valid.
REQ-018 MODE=1: o_ready = !reset && !i_flush && !skid_valid, driven purely from flops and those two inputs; o_ready SHALL NOT depend on i_ready.
REQ-019 MODE=1 state machine, with states EMPTY(level 0), BUSY(level 1) and FULL(level 2):
- EMPTY: input transfer -> BUSY, main <= i_data. Otherwise stay EMPTY.
- BUSY: input and output transfer -> BUSY, main <= i_data. Input only -> FULL, skid <= i_data. Output only -> EMPTY. Neither -> stay BUSY.
- FULL: output transfer -> BUSY, main <= skid. No input accepted while in FULL.
REQ-020 Payload SHALL be delivered in acceptance order; none dropped or duplicated except by flush or reset.
REQ-021 o_data SHALL stay stable while o_valid && !i_ready.
REQ-022 i_flush SHALL take priority over all transfers:
- Next state is EMPTY and o_level = 0.
- Any same-cycle input is discarded.
- Any same-cycle output transfer still counts as delivered downstream.
REQ-023 With CLR_ON_FLUSH=1, flush SHALL zero the main and skid registers. With CLR_ON_FLUSH=0, both registers hold their values.
REQ-024 o_level SHALL equal the number of valid entries after each edge, with o_valid = (o_level != 0).
REQ-025 Simultaneous i_flush and reset SHALL behave as reset.

Reset
REQ-026 While reset is high, o_ready SHALL be 0.
REQ-027 After the reset edge: o_valid = 0, o_data = 0, skid register = 0, o_level = 0.
REQ-028 o_ready SHALL be 1 in the first cycle after reset deasserts, for both MODE values.
REQ-029 Reset asserted mid-stream SHALL discard all held entries regardless of i_ready.

Verification
REQ-030 Streaming test (MODE=1, DATA_W=32): i_valid = 1 and i_ready = 1 for 8 cycles with data 1..8 -> o_data = 1..8 on consecutive cycles, each 1 cycle after input, with o_level = 1 throughout.
REQ-031 Backpressure test (MODE=1): load 0xA then 0xB while i_ready = 0.
- Expected after load: o_level = 2, o_ready = 0, o_data = 0xA held.
- Then raise i_ready for 2 cycles -> outputs 0xA then 0xB, o_level goes 2 -> 1 -> 0, o_ready = 1 after the first output.
REQ-032 Flush test (CLR_ON_FLUSH=1): from FULL, assert i_flush with i_valid = 1 and data 0xC -> next cycle o_valid = 0, o_level = 0, o_data = 0, and 0xC is never output.
REQ-033 Combinational-ready test (MODE=0): o_valid = 1 and i_ready = 0 -> o_ready = 0. Then set i_ready = 1 with input 0x5 -> o_ready = 1 in the same cycle, and o_data = 0x5 next cycle.
REQ-034 Reset test: reset asserted for 1 cycle while o_level = 2 with i_valid = 1.
- During reset: o_ready = 0.
- Next cycle: o_valid = 0, o_data = 0, o_level = 0, o_ready = 1.
REQ-035 Random test: randomised i_valid, i_ready and i_flush across DATA_W in {1, 64}, MODE in {0, 1} -> scoreboard confirms in-order, lossless delivery between flushes and REQ-021 stability.
